// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - UART receive FIFO (first-word fall-through), optional error counters under UART_RX_FIFO_ERR_CNT_EN
module uart_rx_fifo #(
  parameter int DATA_BITS = 8,
  parameter int DEPTH     = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [DATA_BITS-1:0]     rx_data,
  input  logic                     data_ready,
  input  logic                     parity_err,
  input  logic                     frame_err,
  output logic                     rd_valid,
  input  logic                     rd_ready,
  output logic [DATA_BITS-1:0]     rd_data,
  output logic                     rd_parity_err,
  output logic                     rd_frame_err,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  output logic                     overflow,
  input  logic                     clr_overflow
`ifdef UART_RX_FIFO_ERR_CNT_EN
  ,
  output logic [7:0]               parity_err_cnt,
  output logic [7:0]               frame_err_cnt,
  input  logic                     clr_err_cnt
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = DATA_BITS + 2;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [EW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;
  logic          prev_dr_q;
  logic          push, pop, accept, drop;
  logic [EW-1:0] head;

  assign empty    = (count_q == '0);
  assign full     = (count_q == FULL_CNT);
  assign count    = count_q;
  assign rd_valid = ~empty;
  assign overflow = overflow_q;

  // A held-high data_ready yields a single push; only its rising edge counts.
  assign push   = data_ready & ~prev_dr_q;
  assign pop    = rd_valid & rd_ready;
  // When full, a coincident pop frees the slot the push needs.
  assign accept = push & (~full | pop);
  assign drop   = push & full & ~pop;

  // Head entry is masked to zero when empty so idle reads are deterministic.
  assign head          = empty ? '0 : mem_q[rd_ptr_q];
  assign rd_data       = head[DATA_BITS-1:0];
  assign rd_parity_err = head[DATA_BITS];
  assign rd_frame_err  = head[DATA_BITS+1];

  // Next-state for pointers, occupancy and the sticky overflow flag.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (accept) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)    rd_ptr_d = rd_ptr_q + 1'b1;
    case ({accept, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    if (drop)              overflow_d = 1'b1;
    else if (clr_overflow) overflow_d = 1'b0;
  end

  // Control state; prev_dr resets high so a strobe held across reset release is ignored.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      prev_dr_q  <= 1'b1;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      prev_dr_q  <= data_ready;
    end
  end

  // Storage array; contents need no reset because empty masks the head.
  always_ff @(posedge clk) begin
    if (accept) mem_q[wr_ptr_q] <= {frame_err, parity_err, rx_data};
  end

`ifdef UART_RX_FIFO_ERR_CNT_EN
  logic [7:0] pe_cnt_q, pe_cnt_d;
  logic [7:0] fe_cnt_q, fe_cnt_d;

  assign parity_err_cnt = pe_cnt_q;
  assign frame_err_cnt  = fe_cnt_q;

  // Saturating error tallies over every push strobe, dropped words included.
  always_comb begin
    pe_cnt_d = pe_cnt_q;
    fe_cnt_d = fe_cnt_q;
    if (push && parity_err) begin
      if (pe_cnt_q != 8'hFF) pe_cnt_d = pe_cnt_q + 8'd1;
    end else if (clr_err_cnt) begin
      pe_cnt_d = 8'd0;
    end
    if (push && frame_err) begin
      if (fe_cnt_q != 8'hFF) fe_cnt_d = fe_cnt_q + 8'd1;
    end else if (clr_err_cnt) begin
      fe_cnt_d = 8'd0;
    end
  end

  // Error counter registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pe_cnt_q <= 8'd0;
      fe_cnt_q <= 8'd0;
    end else begin
      pe_cnt_q <= pe_cnt_d;
      fe_cnt_q <= fe_cnt_d;
    end
  end
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - scoreboard testbench for uart_rx_fifo
module tb_uart_rx_fifo;

  localparam int DB    = 8;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [DB-1:0] rx_data = '0;
  logic          data_ready = 1'b1;
  logic          parity_err = 1'b0;
  logic          frame_err = 1'b0;
  logic          rd_valid;
  logic          rd_ready = 1'b0;
  logic [DB-1:0] rd_data;
  logic          rd_parity_err;
  logic          rd_frame_err;
  logic [4:0]    count;
  logic          full;
  logic          empty;
  logic          overflow;
  logic          clr_overflow = 1'b0;
`ifdef UART_RX_FIFO_ERR_CNT_EN
  logic [7:0]    parity_err_cnt;
  logic [7:0]    frame_err_cnt;
  logic          clr_err_cnt = 1'b0;
`endif

  int checks = 0;
  int errors = 0;

  // Reference model state: occupancy, sticky overflow, expected words in order.
  logic [DB+1:0] exp_q[$];
  int            m_cnt = 0;
  bit            m_ov = 0;
  bit            m_prev = 1;
  int            m_pc = 0;
  int            m_fc = 0;

  uart_rx_fifo #(.DATA_BITS(DB), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n), .rx_data(rx_data), .data_ready(data_ready),
    .parity_err(parity_err), .frame_err(frame_err), .rd_valid(rd_valid),
    .rd_ready(rd_ready), .rd_data(rd_data), .rd_parity_err(rd_parity_err),
    .rd_frame_err(rd_frame_err), .count(count), .full(full), .empty(empty),
    .overflow(overflow), .clr_overflow(clr_overflow)
`ifdef UART_RX_FIFO_ERR_CNT_EN
    , .parity_err_cnt(parity_err_cnt), .frame_err_cnt(frame_err_cnt),
    .clr_err_cnt(clr_err_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: every clock edge, decide push/pop from the bench's own stimulus.
  always @(posedge clk or negedge reset_n) begin
    bit m_push, m_pop;
    if (!reset_n) begin
      exp_q.delete();
      m_cnt  = 0;
      m_ov   = 0;
      m_prev = 1;
      m_pc   = 0;
      m_fc   = 0;
    end else begin
      m_push = data_ready && !m_prev;
      m_prev = data_ready;
      m_pop  = (m_cnt > 0) && rd_ready;
      if (m_pop) m_cnt--;
      if (m_push) begin
        if (m_cnt < DEPTH) begin
          m_cnt++;
          exp_q.push_back({frame_err, parity_err, rx_data});
          if (clr_overflow) m_ov = 0;
        end else begin
          m_ov = 1;
        end
      end else if (clr_overflow) begin
        m_ov = 0;
      end
`ifdef UART_RX_FIFO_ERR_CNT_EN
      if (m_push && parity_err) m_pc = (m_pc < 255) ? m_pc + 1 : 255;
      else if (clr_err_cnt)     m_pc = 0;
      if (m_push && frame_err)  m_fc = (m_fc < 255) ? m_fc + 1 : 255;
      else if (clr_err_cnt)     m_fc = 0;
`endif
    end
  end

  // Monitor: sample away from the active edge; pop scoreboard on each handshake.
  always @(negedge clk) begin
    logic [DB+1:0] e;
    if (reset_n) begin
      chk("count", 32'(count), 32'(m_cnt));
      chk("rd_valid", 32'(rd_valid), 32'(m_cnt != 0));
      chk("empty", 32'(empty), 32'(m_cnt == 0));
      chk("full", 32'(full), 32'(m_cnt == DEPTH));
      chk("overflow", 32'(overflow), 32'(m_ov));
`ifdef UART_RX_FIFO_ERR_CNT_EN
      chk("parity_err_cnt", 32'(parity_err_cnt), 32'(m_pc));
      chk("frame_err_cnt", 32'(frame_err_cnt), 32'(m_fc));
`endif
      if (!rd_valid) begin
        chk("empty_head", 32'({rd_frame_err, rd_parity_err, rd_data}), 32'd0);
      end else if (rd_ready) begin
        if (exp_q.size() == 0) begin
          chk("scoreboard_underrun", 32'(rd_valid), 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("head_word", 32'({rd_frame_err, rd_parity_err, rd_data}), 32'(e));
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic [DB-1:0] d, input logic pe, input logic fe);
    rx_data = d; parity_err = pe; frame_err = fe; data_ready = 1'b1;
    step();
    data_ready = 1'b0; parity_err = 1'b0; frame_err = 1'b0;
    step();
  endtask

  task automatic drain();
    int n = 0;
    rd_ready = 1'b1;
    while (m_cnt != 0 && n < 4 * DEPTH) begin
      step();
      n++;
    end
    rd_ready = 1'b0;
    chk("drain_bound", 32'(m_cnt), 32'd0);
    step();
  endtask

  initial begin
    // Reset with data_ready held high across release.
    rx_data = 8'h99;
    repeat (3) step();
    reset_n = 1'b1;
    repeat (3) step();
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_valid", 32'(rd_valid), 32'd0);
    data_ready = 1'b0;
    step();

    // Three single-cycle pulses, then read back in order.
    pulse(8'h41, 0, 0);
    pulse(8'h42, 0, 0);
    pulse(8'h43, 0, 0);
    chk("three_count", 32'(count), 32'd3);
    chk("three_head", 32'(rd_data), 32'h41);
    drain();
    chk("three_empty", 32'(empty), 32'd1);

    // Held-high strobe stores exactly one word.
    rx_data = 8'h55; data_ready = 1'b1;
    repeat (5) step();
    data_ready = 1'b0;
    step();
    chk("held_count", 32'(count), 32'd1);
    drain();

    // Fill, overflow, drain, clear.
    for (int i = 0; i < DEPTH; i++) pulse(8'(i), 0, 0);
    pulse(8'hFF, 0, 0);
    chk("ovf_full", 32'(full), 32'd1);
    chk("ovf_flag", 32'(overflow), 32'd1);
    drain();
    chk("ovf_sticky", 32'(overflow), 32'd1);
    clr_overflow = 1'b1; step(); clr_overflow = 1'b0; step();
    chk("ovf_clear", 32'(overflow), 32'd0);

    // Full FIFO with a push coincident with a pop.
    for (int i = 0; i < DEPTH; i++) pulse(8'(8'h60 + i), 0, 0);
    rx_data = 8'hAA; data_ready = 1'b1; rd_ready = 1'b1;
    step();
    data_ready = 1'b0; rd_ready = 1'b0;
    step();
    chk("pp_count", 32'(count), 32'd16);
    chk("pp_ovf", 32'(overflow), 32'd0);
    drain();

    // Error flags travel with their words.
    pulse(8'h12, 1, 0);
    pulse(8'h34, 0, 1);
    chk("flags_head0", 32'({rd_frame_err, rd_parity_err, rd_data}), 32'h112);
    rd_ready = 1'b1; step(); rd_ready = 1'b0;
    chk("flags_head1", 32'({rd_frame_err, rd_parity_err, rd_data}), 32'h234);
    drain();

    // Randomised traffic: a fill-heavy phase then a balanced phase.
    for (int c = 0; c < 2000; c++) begin
      data_ready   = ($urandom_range(0, 2) == 0);
      rx_data      = 8'($urandom);
      parity_err   = ($urandom_range(0, 7) == 0);
      frame_err    = ($urandom_range(0, 7) == 0);
      rd_ready     = (c < 800) ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 1) == 0);
      clr_overflow = ($urandom_range(0, 19) == 0);
      step();
    end
    data_ready = 1'b0; clr_overflow = 1'b0; parity_err = 1'b0; frame_err = 1'b0;
    step();
    drain();

    // Reset mid-operation, asserted off the clock edge.
    pulse(8'h77, 0, 0);
    pulse(8'h78, 1, 1);
    @(posedge clk); #3;
    reset_n = 1'b0;
    #1;
    chk("arst_count", 32'(count), 32'd0);
    chk("arst_valid", 32'(rd_valid), 32'd0);
    chk("arst_head", 32'({rd_frame_err, rd_parity_err, rd_data}), 32'd0);
    repeat (2) step();
    reset_n = 1'b1;
    step();

`ifdef UART_RX_FIFO_ERR_CNT_EN
    pulse(8'h12, 1, 0);
    pulse(8'h34, 0, 1);
    chk("pe_cnt_one", 32'(parity_err_cnt), 32'd1);
    chk("fe_cnt_one", 32'(frame_err_cnt), 32'd1);
    rd_ready = 1'b1;
    for (int i = 0; i < 300; i++) pulse(8'(i), 1, 0);
    rd_ready = 1'b0;
    chk("pe_cnt_sat", 32'(parity_err_cnt), 32'd255);
    drain();
    clr_err_cnt = 1'b1; step(); clr_err_cnt = 1'b0; step();
    chk("pe_cnt_clr", 32'(parity_err_cnt), 32'd0);
    chk("fe_cnt_clr", 32'(frame_err_cnt), 32'd0);
`endif

    drain();
    chk("sb_leftover", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
